// File: rtl/l2_mem_burst_arbiter_pkg.sv
// Shared widths, state/grant encodings and arbitration helpers for the
// L2 <-> main-memory burst arbiter.
package l2_mem_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH_MEM = 64;
  localparam int BURST_LENGTH   = 8;
  localparam int BEAT_CNT_WIDTH = 3;
  localparam int LINE_ADDR_LSB  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    BURST = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic {
    GRANT_FILL = 1'b0,
    GRANT_WB   = 1'b1
  } grant_t;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'((1 << LINE_ADDR_LSB) - 1);
  endfunction

  // A writeback to the line being filled must land first, else memory
  // would return stale data for the fill.
  function automatic grant_t pick_grant(input logic                  fill_req,
                                        input logic                  wb_req,
                                        input logic [ADDR_WIDTH-1:0] fill_addr,
                                        input logic [ADDR_WIDTH-1:0] wb_addr,
                                        input grant_t                last_grant);
    grant_t g;
    if (fill_req && wb_req) begin
      if ((fill_addr >> LINE_ADDR_LSB) == (wb_addr >> LINE_ADDR_LSB)) g = GRANT_WB;
      else g = (last_grant == GRANT_FILL) ? GRANT_WB : GRANT_FILL;
    end else if (wb_req) begin
      g = GRANT_WB;
    end else begin
      g = GRANT_FILL;
    end
    return g;
  endfunction

endpackage

// File: rtl/l2_mem_burst_arbiter_if.sv
// Main-memory burst bus. The bus has no valid/ready pair: a burst starts on each
// addrstb_MEM toggle and every stb toggle from memory transfers exactly one beat.
interface l2_mem_burst_arbiter_if;
  import l2_mem_pkg::*;

  logic                      addrstb_MEM;
  logic [ADDR_WIDTH-1:0]     addr_MEM;
  logic                      we_MEM;
  logic                      data_oe_MEM;
  logic [DATA_WIDTH_MEM-1:0] data_out_MEM;
  logic [DATA_WIDTH_MEM-1:0] data_in_MEM;
  logic                      stb;

  modport master (
    output addrstb_MEM, addr_MEM, we_MEM, data_oe_MEM, data_out_MEM,
    input  data_in_MEM, stb
  );

  modport slave (
    input  addrstb_MEM, addr_MEM, we_MEM, data_oe_MEM, data_out_MEM,
    output data_in_MEM, stb
  );
endinterface

// File: rtl/l2_mem_burst_arbiter_stb_toggle_det.sv
// Turns the memory's toggle-encoded beat strobe into a one-cycle pulse.
module mem_stb_toggle_det (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  output logic toggle
);
  logic stb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stb_q <= 1'b0;
    else     stb_q <= stb;
  end

  assign toggle = stb ^ stb_q;
endmodule

// File: rtl/l2_mem_burst_arbiter.sv
// Arbitrates the single memory burst bus between L2 miss fills (reads) and
// dirty-line writebacks (writes), sequencing one line burst at a time.
module l2_mem_burst_arbiter
  import l2_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fill_req,
  input  logic [ADDR_WIDTH-1:0]     fill_addr,
  output logic                      fill_gnt,
  output logic [DATA_WIDTH_MEM-1:0] fill_rdata,
  output logic                      fill_beat_vld,
  output logic [BEAT_CNT_WIDTH-1:0] fill_beat_idx,
  output logic                      fill_done,
  output logic                      fill_err,
  input  logic                      wb_req,
  input  logic [ADDR_WIDTH-1:0]     wb_addr,
  input  logic [DATA_WIDTH_MEM-1:0] wb_wdata,
  output logic [BEAT_CNT_WIDTH-1:0] wb_beat_idx,
  output logic                      wb_gnt,
  output logic                      wb_done,
  output logic                      wb_err,
  l2_mem_burst_arbiter_if.master    mem,
  output state_t                    state_dbg
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]          TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BURST_LENGTH - 1);

  state_t                    state_q, state_d;
  grant_t                    winner_q, last_grant_q, pick;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      toggle, burst_tog, tmo_hit, is_wr, granted, finishing;

  mem_stb_toggle_det u_stb_det (
    .clk    (clk),
    .rst    (rst),
    .stb    (mem.stb),
    .toggle (toggle)
  );

  assign pick      = pick_grant(fill_req, wb_req, fill_addr, wb_addr, last_grant_q);
  assign burst_tog = toggle && (state_q == BURST);
  // Timeout fires when the idle count would reach TIMEOUT_CYCLES this edge.
  assign tmo_hit   = !burst_tog && (tmo_cnt == TMO_LAST);
  assign is_wr     = (winner_q == GRANT_WB);
  assign granted   = (state_q != IDLE);
  assign finishing = (state_q == DONE) || (state_q == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_req || wb_req) state_d = ADDR;
      ADDR:    state_d = tmo_hit ? ERR : BURST;
      BURST: begin
        if (burst_tog && (beat_cnt == LAST_BEAT)) state_d = DONE;
        else if (tmo_hit)                         state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_gnt  = granted && !is_wr;
  assign wb_gnt    = granted && is_wr;
  assign fill_done = finishing && !is_wr;
  assign wb_done   = finishing && is_wr;
  assign fill_err  = (state_q == ERR) && !is_wr;
  assign wb_err    = (state_q == ERR) && is_wr;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q         <= GRANT_FILL;
      last_grant_q     <= GRANT_FILL;
      beat_cnt         <= '0;
      tmo_cnt          <= '0;
      fill_rdata       <= '0;
      fill_beat_vld    <= 1'b0;
      fill_beat_idx    <= '0;
      wb_beat_idx      <= '0;
      mem.addrstb_MEM  <= 1'b0;
      mem.addr_MEM     <= '0;
      mem.we_MEM       <= MEM_READ;
      mem.data_oe_MEM  <= 1'b0;
      mem.data_out_MEM <= '0;
    end else begin
      fill_beat_vld <= 1'b0;
      if (state_q == IDLE && state_d == ADDR) begin
        winner_q         <= pick;
        last_grant_q     <= pick;
        mem.addr_MEM     <= line_align((pick == GRANT_WB) ? wb_addr : fill_addr);
        mem.we_MEM       <= (pick == GRANT_WB) ? MEM_WRITE : MEM_READ;
        mem.data_oe_MEM  <= (pick == GRANT_WB);
        mem.data_out_MEM <= (pick == GRANT_WB) ? wb_wdata : '0;
        mem.addrstb_MEM  <= ~mem.addrstb_MEM;
        wb_beat_idx      <= '0;
        beat_cnt         <= '0;
        tmo_cnt          <= '0;
      end
      if (state_q == ADDR || state_q == BURST) begin
        tmo_cnt <= burst_tog ? '0 : tmo_cnt + 1'b1;
        // wb_wdata follows wb_beat_idx, so the next beat lands one edge after the index moves.
        if (is_wr) mem.data_out_MEM <= wb_wdata;
      end
      if (burst_tog) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (is_wr) begin
          wb_beat_idx <= wb_beat_idx + 1'b1;
        end else begin
          fill_rdata    <= mem.data_in_MEM;
          fill_beat_idx <= beat_cnt;
          fill_beat_vld <= 1'b1;
        end
      end
      if (state_d == DONE || state_d == ERR) begin
        mem.data_oe_MEM <= 1'b0;
        mem.we_MEM      <= MEM_READ;
        wb_beat_idx     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_l2_mem_burst_arbiter.sv
// Scenario bench for the burst arbiter: the bench plays both L2 requesters and
// main memory, and predicts winners, addresses and beat data from the line rules.
module tb_l2_mem_burst_arbiter;
  import l2_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        fill_req, wb_req;
  logic [31:0] fill_addr, wb_addr;
  logic [63:0] wb_wdata, fill_rdata, wb_base;
  logic        fill_gnt, fill_beat_vld, fill_done, fill_err;
  logic        wb_gnt, wb_done, wb_err;
  logic [2:0]  fill_beat_idx, wb_beat_idx;
  state_t      state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [2:0]  exp_idx_q[$];
  logic [63:0] mon_d;
  logic [2:0]  mon_i;
  int          vld_count;
  logic        addrstb_prev;
  bit          ref_last_wb;

  l2_mem_burst_arbiter_if mem();

  l2_mem_burst_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .fill_req      (fill_req),
    .fill_addr     (fill_addr),
    .fill_gnt      (fill_gnt),
    .fill_rdata    (fill_rdata),
    .fill_beat_vld (fill_beat_vld),
    .fill_beat_idx (fill_beat_idx),
    .fill_done     (fill_done),
    .fill_err      (fill_err),
    .wb_req        (wb_req),
    .wb_addr       (wb_addr),
    .wb_wdata      (wb_wdata),
    .wb_beat_idx   (wb_beat_idx),
    .wb_gnt        (wb_gnt),
    .wb_done       (wb_done),
    .wb_err        (wb_err),
    .mem           (mem),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L2 data array model: beat n of the victim line is wb_base + n.
  assign wb_wdata = wb_base + 64'(wb_beat_idx);

  // Scoreboard for delivered fill beats
  always @(negedge clk) begin
    if (fill_beat_vld === 1'b1) begin
      vld_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fill_beat_extra: beat idx=%0d data=%h with nothing expected", fill_beat_idx, fill_rdata);
      end else begin
        mon_d = exp_q.pop_front();
        mon_i = exp_idx_q.pop_front();
        if ({fill_rdata, fill_beat_idx} !== {mon_d, mon_i}) begin
          errors++;
          $display("FAIL fill_beat: got idx=%0d data=%h, want idx=%0d data=%h", fill_beat_idx, fill_rdata, mon_i, mon_d);
        end
      end
    end
  end

  // Reference arbitration: lines are 64 B; a shared line forces the writeback first,
  // otherwise a contested grant alternates.
  function automatic bit ref_wb_wins(bit f, bit w, logic [31:0] fa, logic [31:0] wa, bit last_wb);
    if (!f) return 1'b1;
    if (!w) return 1'b0;
    if ((fa / 64) == (wa / 64)) return 1'b1;
    return !last_wb;
  endfunction

  // Driver: plays memory for one granted burst and handles the done handshake.
  task automatic run_txn(input bit exp_wb, input int n_toggles, input bit exp_timeout,
                         input bit directed, input string name);
    logic [31:0] a_exp;
    logic [63:0] d;
    bit          got;
    int          waited;
    a_exp = (exp_wb ? wb_addr : fill_addr) & 32'hFFFF_FFC0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem.addrstb_MEM !== addrstb_prev) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_addrstb: no addrstb_MEM toggle within 20 cycles", name);
      return;
    end
    addrstb_prev = mem.addrstb_MEM;
    ref_last_wb  = exp_wb;
    checks++;
    if ({fill_gnt, wb_gnt} !== {!exp_wb, exp_wb}) begin
      errors++;
      $display("FAIL %s_grant: fill_gnt=%b wb_gnt=%b, want wb winner=%b", name, fill_gnt, wb_gnt, exp_wb);
    end
    checks++;
    if (mem.addr_MEM !== a_exp) begin
      errors++;
      $display("FAIL %s_addr: addr_MEM=%h want %h", name, mem.addr_MEM, a_exp);
    end
    checks++;
    if ({mem.we_MEM, mem.data_oe_MEM} !== {!exp_wb, exp_wb}) begin
      errors++;
      $display("FAIL %s_dir: we_MEM=%b data_oe_MEM=%b want %b %b", name, mem.we_MEM, mem.data_oe_MEM, !exp_wb, exp_wb);
    end
    vld_count = 0;
    for (int i = 0; i < n_toggles; i++) begin
      repeat (exp_wb ? $urandom_range(2, 4) : $urandom_range(1, 3)) @(negedge clk);
      if (exp_wb) begin
        checks++;
        if (mem.data_out_MEM !== wb_base + 64'(i)) begin
          errors++;
          $display("FAIL %s_wbeat%0d: data_out_MEM=%h want %h", name, i, mem.data_out_MEM, wb_base + 64'(i));
        end
      end else begin
        d = directed ? 64'h10 + 64'(i) : {$urandom, $urandom};
        mem.data_in_MEM = d;
        exp_q.push_back(d);
        exp_idx_q.push_back(3'(i));
      end
      mem.stb = ~mem.stb;
    end
    got = 1'b0;
    waited = 0;
    for (int c = 0; c < (exp_timeout ? 400 : 10) && !got; c++) begin
      @(negedge clk);
      waited++;
      if (fill_done === 1'b1 || wb_done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done: no done within %0d cycles", name, waited);
    end else begin
      checks++;
      if ({fill_done, fill_err, wb_done, wb_err} !==
          {!exp_wb, !exp_wb && exp_timeout, exp_wb, exp_wb && exp_timeout}) begin
        errors++;
        $display("FAIL %s_status: fill_done/err=%b%b wb_done/err=%b%b", name, fill_done, fill_err, wb_done, wb_err);
      end
      if (exp_timeout) begin
        checks++;
        if (waited < 250 || waited > 262) begin
          errors++;
          $display("FAIL %s_tmo_len: err after %0d idle cycles, want about 255", name, waited);
        end
      end
    end
    if (exp_wb) wb_req = 1'b0;
    else        fill_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({fill_done, wb_done, fill_err, wb_err, fill_gnt, wb_gnt, mem.data_oe_MEM, mem.we_MEM} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL %s_after: done=%b%b err=%b%b gnt=%b%b oe=%b we=%b", name, fill_done, wb_done,
               fill_err, wb_err, fill_gnt, wb_gnt, mem.data_oe_MEM, mem.we_MEM);
    end
    if (!exp_wb) begin
      checks++;
      if (vld_count != n_toggles || exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s_beats: %0d beats delivered, %0d pending, want %0d delivered", name, vld_count, exp_q.size(), n_toggles);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    mem.stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    addrstb_prev = 1'b0;
    ref_last_wb  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({fill_gnt, fill_beat_vld, fill_done, fill_err, wb_gnt, wb_done, wb_err,
         mem.addrstb_MEM, mem.data_oe_MEM, mem.we_MEM} !== 10'b00_0000_0001 ||
        mem.addr_MEM !== 32'h0 || mem.data_out_MEM !== 64'h0 || fill_rdata !== 64'h0 ||
        fill_beat_idx !== 3'd0 || wb_beat_idx !== 3'd0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_values: gnt=%b%b we=%b oe=%b addrstb=%b addr=%h state=%0d",
               fill_gnt, wb_gnt, mem.we_MEM, mem.data_oe_MEM, mem.addrstb_MEM, mem.addr_MEM, state_dbg);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fill_gnt, wb_gnt, mem.addrstb_MEM} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_req: gnt=%b%b addrstb=%b, want 000", fill_gnt, wb_gnt, mem.addrstb_MEM);
    end
  endtask

  task automatic test_fill_alone();
    fill_addr = 32'h0001_2345;
    fill_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b1, "fill_alone");
  endtask

  task automatic test_wb_alone();
    wb_addr = 32'h0000_0080;
    wb_base = 64'hA0;
    wb_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "wb_alone");
  endtask

  task automatic test_arbitration();
    pulse_reset();
    fill_addr = $urandom;
    wb_addr   = fill_addr + 32'h40 * $urandom_range(1, 1000);
    wb_base   = {$urandom, $urandom};
    fill_req  = 1'b1;
    wb_req    = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "rr_first");
    wb_addr = fill_addr + 32'h40 * $urandom_range(1, 1000);
    wb_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "rr_second");
    fill_addr = wb_addr + 32'h40 * $urandom_range(1, 1000);
    fill_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "rr_third");
  endtask

  task automatic test_same_line();
    fill_addr = 32'h0000_0100;
    wb_addr   = 32'h0000_013C;
    wb_base   = 64'h5500;
    fill_req  = 1'b1;
    wb_req    = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "same_line_wb");
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "same_line_fill");
  endtask

  task automatic test_timeout();
    fill_addr = $urandom;
    fill_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 3, 1'b1, 1'b0, "timeout");
    fill_addr = $urandom;
    fill_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    fill_addr = $urandom;
    fill_req  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem.addrstb_MEM !== addrstb_prev) got = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      mem.data_in_MEM = {$urandom, $urandom};
      exp_q.push_back(mem.data_in_MEM);
      exp_idx_q.push_back(3'(i));
      mem.stb = ~mem.stb;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({fill_gnt, fill_beat_vld, fill_done, fill_err, wb_gnt, wb_done, wb_err,
         mem.addrstb_MEM, mem.data_oe_MEM, mem.we_MEM} !== 10'b00_0000_0001 ||
        mem.addr_MEM !== 32'h0 || fill_rdata !== 64'h0 || fill_beat_idx !== 3'd0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_burst: gnt=%b addrstb=%b addr=%h rdata=%h state=%0d",
               fill_gnt, mem.addrstb_MEM, mem.addr_MEM, fill_rdata, state_dbg);
    end
    fill_req = 1'b0;
    mem.stb  = 1'b0;
    exp_q.delete();
    exp_idx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    addrstb_prev = 1'b0;
    ref_last_wb  = 1'b0;
    fill_addr = $urandom;
    fill_req  = 1'b1;
    run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "post_reset_fill");
  endtask

  task automatic test_random_traffic();
    for (int k = 0; k < 8; k++) begin
      if (!fill_req && $urandom_range(0, 1) == 1) begin
        fill_req  = 1'b1;
        fill_addr = $urandom;
      end
      if (!wb_req && $urandom_range(0, 1) == 1) begin
        wb_req  = 1'b1;
        wb_addr = ($urandom_range(0, 2) == 0) ? {fill_addr[31:6], 6'($urandom)} : $urandom;
        wb_base = {$urandom, $urandom};
      end
      if (!fill_req && !wb_req) begin
        fill_req  = 1'b1;
        fill_addr = $urandom;
      end
      run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "random");
    end
    for (int k = 0; k < 2 && (fill_req || wb_req); k++)
      run_txn(ref_wb_wins(fill_req, wb_req, fill_addr, wb_addr, ref_last_wb), 8, 1'b0, 1'b0, "random_drain");
  endtask

  initial begin
    rst             = 1'b1;
    fill_req        = 1'b0;
    wb_req          = 1'b0;
    fill_addr       = '0;
    wb_addr         = '0;
    wb_base         = '0;
    mem.stb         = 1'b0;
    mem.data_in_MEM = '0;
    addrstb_prev    = 1'b0;
    ref_last_wb     = 1'b0;
    vld_count       = 0;
    test_reset();
    test_fill_alone();
    test_wb_alone();
    test_arbitration();
    test_same_line();
    test_timeout();
    test_reset_mid_burst();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
